// File: rtl/mic_frame_sched.sv
// Ping-pong frame scheduler: packs mic samples into two banks and hands full banks to the frame engine.
// Optional engine watchdog is enabled by defining MIC_FRAME_TIMEOUT_EN.
module mic_frame_sched #(
    parameter int SAMPLE_W    = 24,
    parameter int FRAME_LEN   = 16,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 1024,
    localparam int ADDR_W     = $clog2(FRAME_LEN)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] mic,
    input  logic                mic_valid,
    output logic                eng_start,
    output logic                eng_bank,
    input  logic [ADDR_W-1:0]   eng_rd_addr,
    output logic [SAMPLE_W-1:0] eng_rd_data,
    input  logic                eng_done,
    output logic                busy,
    output logic                overrun,
    output logic [CNT_W-1:0]    frame_cnt,
    output logic                timeout
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_LEN - 1);

    if (FRAME_LEN < 2 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("mic_frame_sched: FRAME_LEN must be >= 2 and TIMEOUT_CYC >= 1");
    end

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state, state_nx;
    logic [SAMPLE_W-1:0] mem [0:2*FRAME_LEN-1];
    logic                wr_bank;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [1:0]          full, full_nx;
    logic                dispatch, release_bank, done_ok, disp_bank;
    logic                wr_free, wr_en, wd_fire;

    // A bank is writable only if it is neither waiting (FULL) nor owned by the engine (PROC).
    assign wr_free = !full[wr_bank] && !(state == BUSY && eng_bank == wr_bank);
    assign wr_en   = mic_valid && wr_free;
    assign done_ok = (state == BUSY) && eng_done && !eng_start;

    always_comb begin
        state_nx     = state;
        dispatch     = 1'b0;
        release_bank = 1'b0;
        disp_bank    = full[1];
        full_nx      = full;
        case (state)
            IDLE: begin
                if (|full) begin
                    dispatch = 1'b1;
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                if (done_ok || wd_fire) begin
                    release_bank = 1'b1;
                    state_nx     = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (dispatch)
            full_nx[disp_bank] = 1'b0;
        if (wr_en && wr_ptr == LAST)
            full_nx[wr_bank] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            eng_start   <= 1'b0;
            eng_bank    <= 1'b0;
            eng_rd_data <= '0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
            frame_cnt   <= '0;
            wr_bank     <= 1'b0;
            wr_ptr      <= '0;
            full        <= 2'b00;
        end else begin
            eng_start   <= dispatch;
            eng_rd_data <= mem[{eng_bank, eng_rd_addr}];
            full        <= full_nx;
            if (dispatch) begin
                eng_bank  <= disp_bank;
                busy      <= 1'b1;
                frame_cnt <= frame_cnt + 1'b1;
            end
            if (release_bank)
                busy <= 1'b0;
            if (mic_valid && !wr_free)
                overrun <= 1'b1;
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (wr_ptr == LAST)
                    wr_bank <= ~wr_bank;
            end
        end
    end

    // Sample RAM is deliberately left uninitialised by reset.
    always_ff @(posedge clk) begin
        if (wr_en && !rst)
            mem[{wr_bank, wr_ptr}] <= mic;
    end

`ifdef MIC_FRAME_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            timeout_q;

    // Counter is 0 during the start cycle, so the release lands after TIMEOUT_CYC busy cycles.
    assign wd_fire = (state == BUSY) && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
    assign timeout = timeout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (dispatch)
                wd_cnt <= '0;
            else if (state == BUSY)
                wd_cnt <= wd_cnt + 1'b1;
            if (wd_fire && !done_ok)
                timeout_q <= 1'b1;
        end
    end
`else
    assign wd_fire = 1'b0;
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mic_frame_sched.sv
// Directed bench for mic_frame_sched: dispatch latency, ping-pong hand-off, overrun, reset, watchdog.
module tb_mic_frame_sched;

    logic        clk;
    logic        rst;
    logic [23:0] mic;
    logic        mic_valid;
    logic        eng_start;
    logic        eng_bank;
    logic [3:0]  eng_rd_addr;
    logic [23:0] eng_rd_data;
    logic        eng_done;
    logic        busy;
    logic        overrun;
    logic [15:0] frame_cnt;
    logic        timeout;

    int n_chk;
    int n_fail;
    int ticks;
    int t_disp;

    mic_frame_sched dut (
        .clk         (clk),
        .rst         (rst),
        .mic         (mic),
        .mic_valid   (mic_valid),
        .eng_start   (eng_start),
        .eng_bank    (eng_bank),
        .eng_rd_addr (eng_rd_addr),
        .eng_rd_data (eng_rd_data),
        .eng_done    (eng_done),
        .busy        (busy),
        .overrun     (overrun),
        .frame_cnt   (frame_cnt),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1ns later, away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        ticks++;
    endtask

    task automatic send(input logic [23:0] s);
        mic       = s;
        mic_valid = 1'b1;
        tick();
        mic_valid = 1'b0;
    endtask

    task automatic fill(input logic [23:0] base, input int n);
        for (int i = 0; i < n; i++)
            send(base + 24'(i));
    endtask

    task automatic done_pulse();
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [3:0] a, input logic [23:0] exp);
        eng_rd_addr = a;
        tick();
        check(tag, 32'(eng_rd_data), 32'(exp));
    endtask

    initial begin
        n_chk = 0; n_fail = 0; ticks = 0; t_disp = 0;
        rst = 1'b0; mic = '0; mic_valid = 1'b0; eng_rd_addr = '0; eng_done = 1'b0;

        // 1: reset after idle cycles, then eng_done in IDLE is ignored
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_start", 32'(eng_start), 0);
        check("rst_bank", 32'(eng_bank), 0);
        check("rst_rd_data", 32'(eng_rd_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_frame_cnt", 32'(frame_cnt), 0);
        check("rst_timeout", 32'(timeout), 0);
        done_pulse();
        tick();
        check("idle_done_busy", 32'(busy), 0);
        check("idle_done_start", 32'(eng_start), 0);
        check("idle_done_cnt", 32'(frame_cnt), 0);

        // 2: first frame into bank0, start one edge after the last write
        fill(24'h000001, 16);
        check("f0_start_early", 32'(eng_start), 0);
        tick();
        check("f0_start", 32'(eng_start), 1);
        check("f0_bank", 32'(eng_bank), 0);
        check("f0_busy", 32'(busy), 1);
        check("f0_cnt", 32'(frame_cnt), 1);
        tick();
        check("f0_start_pulse", 32'(eng_start), 0);
        for (int a = 0; a < 16; a++)
            read_chk("f0_read", 4'(a), 24'(a + 1));

        // 3: bank1 fills while engine busy; dispatched only after done
        fill(24'h100000, 16);
        check("f1_no_start", 32'(eng_start), 0);
        tick();
        check("f1_no_start2", 32'(eng_start), 0);
        check("f1_still_busy", 32'(busy), 1);
        check("f1_no_overrun", 32'(overrun), 0);
        done_pulse();
        check("f1_released", 32'(busy), 0);
        check("f1_start_wait", 32'(eng_start), 0);
        tick();
        check("f1_start", 32'(eng_start), 1);
        check("f1_bank", 32'(eng_bank), 1);
        check("f1_cnt", 32'(frame_cnt), 2);
        read_chk("f1_read15", 4'd15, 24'h10000F);

        // 4: bank0 PROC, bank1 FULL, writer on bank0 -> drops
        fill(24'h200000, 16);
        done_pulse();
        tick();
        check("f2_start", 32'(eng_start), 1);
        check("f2_bank", 32'(eng_bank), 0);
        check("f2_cnt", 32'(frame_cnt), 3);
        fill(24'h300000, 16);
        check("ovr_before", 32'(overrun), 0);
        send(24'hABCDEF);
        check("ovr_set", 32'(overrun), 1);
        tick();
        check("ovr_no_start", 32'(eng_start), 0);
        // sample arriving with the accepted done still sees bank0 as PROC
        mic = 24'h0DEAD1; mic_valid = 1'b1; eng_done = 1'b1;
        tick();
        mic_valid = 1'b0; eng_done = 1'b0;
        check("f3_released", 32'(busy), 0);
        tick();
        check("f3_start", 32'(eng_start), 1);
        check("f3_bank", 32'(eng_bank), 1);
        check("f3_cnt", 32'(frame_cnt), 4);
        send(24'h555555);
        for (int i = 1; i < 16; i++)
            send(24'h400000 + 24'(i));
        tick();
        check("f4_wait_start", 32'(eng_start), 0);
        done_pulse();
        tick();
        check("f4_start", 32'(eng_start), 1);
        check("f4_bank", 32'(eng_bank), 0);
        check("f4_cnt", 32'(frame_cnt), 5);
        read_chk("f4_read0", 4'd0, 24'h555555);
        read_chk("f4_read1", 4'd1, 24'h400001);
        read_chk("f4_read15", 4'd15, 24'h40000F);

        // 5: reset while BUSY with a partial bank1
        fill(24'h600000, 7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_cnt", 32'(frame_cnt), 0);
        check("mid_rst_ovr", 32'(overrun), 0);
        check("mid_rst_bank", 32'(eng_bank), 0);
        fill(24'h700000, 16);
        tick();
        t_disp = ticks;
        check("f5_start", 32'(eng_start), 1);
        check("f5_bank", 32'(eng_bank), 0);
        check("f5_cnt", 32'(frame_cnt), 1);
        read_chk("f5_read0", 4'd0, 24'h700000);
        read_chk("f5_read6", 4'd6, 24'h700006);

        // 6: engine never finishes; bank1 left waiting
        fill(24'h800000, 16);
`ifdef MIC_FRAME_TIMEOUT_EN
        for (int k = 0; k < 2000 && busy; k++)
            tick();
        check("wd_release", 32'(busy), 0);
        check("wd_latency", 32'(ticks - t_disp), 1024);
        check("wd_timeout", 32'(timeout), 1);
        tick();
        check("wd_next_start", 32'(eng_start), 1);
        check("wd_next_bank", 32'(eng_bank), 1);
        check("wd_next_cnt", 32'(frame_cnt), 2);
        check("wd_sticky", 32'(timeout), 1);
`else
        repeat (1100) tick();
        check("nowd_busy", 32'(busy), 1);
        check("nowd_timeout", 32'(timeout), 0);
        check("nowd_no_start", 32'(eng_start), 0);
        check("nowd_cnt", 32'(frame_cnt), 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
